ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter PRG_BASE, default 18'h08995, RAM offset added to ioctl_addr for index-1 (PRG) downloads.
REQ-002 Parameter PTR_BASE, default 18'h083E9, first of four RAM bytes patched with the PRG end pointer.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 ioctl_download / ioctl_wr  in  1 each  download active / byte strobe.
REQ-006 ioctl_index  in  8  0 = raw image, 1 = PRG; ioctl_addr  in  25; ioctl_data  in  8.
REQ-007 eraser_busy / eraser_wr  in  1 each; eraser_addr  in  25; eraser_data  in  8.
REQ-008 vdc_rd / vdc_wr  in  1 each; vdc_addr  in  25; vdc_din  in  8  (VTL chip port).
REQ-009 vdc_wait  out  1  VTL request not served this cycle.
REQ-010 ram_addr  out  18; ram_din  out  8; ram_we  out  1; ram_en  out  1  (to dpram port A).
REQ-011 cpu_hold  out  1  CPU reset request; blank  out  1  video blank request.
REQ-012 erase_conflict  out  1  sticky: eraser write dropped.

Function
REQ-013 State machine states: S_VDC, S_DL, S_PATCH, S_ERASE; reset state S_VDC.
REQ-014 Priority: download > patch > erase > VDC. Transitions are evaluated every clk.
REQ-015 S_VDC -> S_DL when ioctl_download=1; else -> S_ERASE when eraser_busy=1.
REQ-016 S_DL: ioctl_wr=1 drives ram_we=1, ram_en=1, ram_din=ioctl_data, same cycle (combinational from state register).
REQ-017 S_DL address: ram_addr=ioctl_addr[17:0] for index 0; (ioctl_addr+PRG_BASE)[17:0] for index 1, truncated to 18 bits.
REQ-018 S_DL, index 1: on each ioctl_wr, register end_ptr = (PRG_BASE+ioctl_addr+1)[15:0] and set seen_wr.
REQ-019 S_DL exit on ioctl_download=0: to S_PATCH if index 1 and seen_wr; else to S_VDC. seen_wr clears on exit.
REQ-020 S_PATCH: 2-bit counter p, writes one byte per cycle for p=0..3: addr PTR_BASE+p, data = end_ptr[7:0] for even p, end_ptr[15:8] for odd p; ram_we=1.
REQ-021 S_PATCH -> S_VDC after p=3 write (4 cycles total); ioctl_download=1 during S_PATCH aborts the patch -> S_DL next cycle, p cleared.
REQ-022 S_ERASE: pass through eraser_addr[17:0], eraser_data, ram_we=eraser_wr, ram_en=1; exit to S_VDC when eraser_busy=0; to S_DL if ioctl_download=1.
REQ-023 eraser_wr=1 in any state other than S_ERASE: write dropped, erase_conflict set to 1 until reset.
REQ-024 S_VDC: ram_addr=vdc_addr[17:0], ram_din=vdc_din, ram_we=vdc_wr, ram_en=vdc_rd|vdc_wr; read data available on ram_q one cycle later (dpram latency).
REQ-025 vdc_wait = (vdc_rd|vdc_wr) & (state != S_VDC); VTL writes while waiting are not performed.
REQ-026 cpu_hold = ioctl_download | eraser_busy | (state != S_VDC) | reset.
REQ-027 blank = ioctl_download | eraser_busy | (state == S_DL) | (state == S_PATCH).
REQ-028 Outside the cases above ram_we=0, ram_en=0, ram_addr=0, ram_din=0.

Reset
REQ-029 reset=1 forces state S_VDC, p=0, end_ptr=0, seen_wr=0, erase_conflict=0 on the next clk, including mid-download or mid-patch; no RAM write is issued in the reset cycle (ram_we=0).
REQ-030 After reset release, first arbitration occurs on the next clk.

Verification
REQ-031 Index-0 download, ioctl_addr=0x00010, data 0x5A -> ram_addr=0x00010, ram_din=0x5A, ram_we=1 same cycle; cpu_hold=1, blank=1.
REQ-032 Index-1 download of 3 bytes at ioctl_addr 0..2 -> writes at 0x08995..0x08997; after download drops, 4 patch cycles write 0x98,0x89,0x98,0x89 at 0x083E9..0x083EC, then state S_VDC, cpu_hold=0.
REQ-033 ioctl_download rises during patch cycle p=1 -> next cycle S_DL, no further patch writes.
REQ-034 eraser_busy with eraser_wr while in S_VDC idle -> S_ERASE next cycle, writes pass through; eraser_wr during S_DL -> no write, erase_conflict=1.
REQ-035 vdc_rd=1 during S_ERASE -> vdc_wait=1; after eraser_busy=0, vdc_wait=0 and ram_q valid one cycle after the VDC read.
REQ-036 reset asserted mid-download -> all outputs at reset values next clk, erase_conflict=0, no patch sequence.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Arbitrates dpram port A between four sources: the ioctl
//               image/PRG downloader, the PRG end-pointer patcher, the
//               memory eraser and the VTL (VDC) chip port. The priority is
//               download > patch > erase > VDC.
//               Ports:
//                 clk, reset                 - clock, synchronous active-high reset
//                 ioctl_*                    - downloader (index 0 raw, 1 PRG)
//                 eraser_*                   - eraser write stream
//                 vdc_rd/wr/addr/din         - VTL chip request port
//                 vdc_wait                   - VTL request not served this cycle
//                 ram_addr/din/we/en         - dpram port A
//                 cpu_hold, blank            - CPU hold and video blank requests
//                 erase_conflict             - sticky flag: an eraser write was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter logic [17:0] PRG_BASE = 18'h08995,
    parameter logic [17:0] PTR_BASE = 18'h083E9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        eraser_busy,
    input  logic        eraser_wr,
    input  logic [24:0] eraser_addr,
    input  logic [7:0]  eraser_data,
    input  logic        vdc_rd,
    input  logic        vdc_wr,
    input  logic [24:0] vdc_addr,
    input  logic [7:0]  vdc_din,
    output logic        vdc_wait,
    output logic [17:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    output logic        ram_en,
    output logic        cpu_hold,
    output logic        blank,
    output logic        erase_conflict
);

    typedef enum logic [1:0] {
        S_VDC   = 2'd0,
        S_DL    = 2'd1,
        S_PATCH = 2'd2,
        S_ERASE = 2'd3
    } state_t;

    state_t      state_q;
    logic [1:0]  p_q;
    logic [15:0] end_ptr_q;
    logic        seen_wr_q;
    logic        erase_conflict_q;

    logic [24:0] w_prg_addr;
    logic [15:0] w_end_ptr;
    logic        w_is_prg;
    logic        w_vdc_req;
    logic        w_unused;

    assign w_is_prg   = (ioctl_index == 8'd1);
    assign w_prg_addr = ioctl_addr + {7'd0, PRG_BASE};
    // End pointer is the address one past the last PRG byte written.
    assign w_end_ptr  = w_prg_addr[15:0] + 16'd1;
    assign w_vdc_req  = vdc_rd | vdc_wr;
    assign w_unused   = ^{eraser_addr[24:18], vdc_addr[24:18], w_prg_addr[24:18]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_VDC;
            p_q              <= 2'd0;
            end_ptr_q        <= 16'd0;
            seen_wr_q        <= 1'b0;
            erase_conflict_q <= 1'b0;
        end else begin
            // The eraser owns the RAM only in S_ERASE; anything else is lost.
            if (eraser_wr && (state_q != S_ERASE)) begin
                erase_conflict_q <= 1'b1;
            end
            case (state_q)
                S_VDC: begin
                    if (ioctl_download) begin
                        state_q <= S_DL;
                    end else if (eraser_busy) begin
                        state_q <= S_ERASE;
                    end
                end
                S_DL: begin
                    if (ioctl_wr && w_is_prg) begin
                        end_ptr_q <= w_end_ptr;
                        seen_wr_q <= 1'b1;
                    end
                    if (!ioctl_download) begin
                        seen_wr_q <= 1'b0;
                        state_q   <= (w_is_prg && seen_wr_q) ? S_PATCH : S_VDC;
                    end
                end
                S_PATCH: begin
                    // A new download pre-empts the pointer patch entirely.
                    if (ioctl_download) begin
                        state_q <= S_DL;
                        p_q     <= 2'd0;
                    end else if (p_q == 2'd3) begin
                        state_q <= S_VDC;
                        p_q     <= 2'd0;
                    end else begin
                        p_q <= p_q + 2'd1;
                    end
                end
                S_ERASE: begin
                    if (ioctl_download) begin
                        state_q <= S_DL;
                    end else if (!eraser_busy) begin
                        state_q <= S_VDC;
                    end
                end
                default: state_q <= S_VDC;
            endcase
        end
    end

    // RAM port is a combinational mux on the registered state so that each
    // source sees single-cycle write latency. Nothing is written during reset.
    always_comb begin
        ram_addr = 18'd0;
        ram_din  = 8'd0;
        ram_we   = 1'b0;
        ram_en   = 1'b0;
        if (!reset) begin
            case (state_q)
                S_VDC: begin
                    ram_addr = vdc_addr[17:0];
                    ram_din  = vdc_din;
                    ram_we   = vdc_wr;
                    ram_en   = w_vdc_req;
                end
                S_DL: begin
                    if (ioctl_wr) begin
                        ram_addr = w_is_prg ? w_prg_addr[17:0] : ioctl_addr[17:0];
                        ram_din  = ioctl_data;
                        ram_we   = 1'b1;
                        ram_en   = 1'b1;
                    end
                end
                S_PATCH: begin
                    ram_addr = PTR_BASE + {16'd0, p_q};
                    ram_din  = p_q[0] ? end_ptr_q[15:8] : end_ptr_q[7:0];
                    ram_we   = 1'b1;
                    ram_en   = 1'b1;
                end
                S_ERASE: begin
                    ram_addr = eraser_addr[17:0];
                    ram_din  = eraser_data;
                    ram_we   = eraser_wr;
                    ram_en   = 1'b1;
                end
                default: begin
                    ram_addr = 18'd0;
                end
            endcase
        end
    end

    assign vdc_wait       = w_vdc_req & (state_q != S_VDC);
    assign cpu_hold       = ioctl_download | eraser_busy | (state_q != S_VDC) | reset;
    assign blank          = ioctl_download | eraser_busy | (state_q == S_DL) | (state_q == S_PATCH);
    assign erase_conflict = erase_conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter. Each vector drives one
//               cycle of inputs; its expected outputs go to a scoreboard queue
//               and are popped and compared once the outputs have settled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    typedef struct {
        logic        rst, dl, wr;
        logic [7:0]  idx;
        logic [24:0] iaddr;
        logic [7:0]  idata;
        logic        eb, ewr;
        logic [24:0] eaddr;
        logic [7:0]  edata;
        logic        vrd, vwr;
        logic [24:0] vaddr;
        logic [7:0]  vdin;
        logic [17:0] xa;
        logic [7:0]  xd;
        logic        xwe, xen, xwait, xhold, xblank, xconf;
    } vec_t;

    typedef struct {
        logic [17:0] addr;
        logic [7:0]  din;
        logic        we, en, wt, hold, blank, conf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ioctl_download = 1'b0, ioctl_wr = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_data = 8'd0;
    logic        eraser_busy = 1'b0, eraser_wr = 1'b0;
    logic [24:0] eraser_addr = 25'd0;
    logic [7:0]  eraser_data = 8'd0;
    logic        vdc_rd = 1'b0, vdc_wr = 1'b0;
    logic [24:0] vdc_addr = 25'd0;
    logic [7:0]  vdc_din = 8'd0;
    logic        vdc_wait;
    logic [17:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we, ram_en, cpu_hold, blank, erase_conflict;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   vec_no   = 0;
    exp_t exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .eraser_busy    (eraser_busy),
        .eraser_wr      (eraser_wr),
        .eraser_addr    (eraser_addr),
        .eraser_data    (eraser_data),
        .vdc_rd         (vdc_rd),
        .vdc_wr         (vdc_wr),
        .vdc_addr       (vdc_addr),
        .vdc_din        (vdc_din),
        .vdc_wait       (vdc_wait),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_we         (ram_we),
        .ram_en         (ram_en),
        .cpu_hold       (cpu_hold),
        .blank          (blank),
        .erase_conflict (erase_conflict)
    );

    function automatic vec_t mk(
        input logic rst, dl, wr, input logic [7:0] idx, input logic [24:0] iaddr, input logic [7:0] idata,
        input logic eb, ewr, input logic [24:0] eaddr, input logic [7:0] edata,
        input logic vrd, vwr, input logic [24:0] vaddr, input logic [7:0] vdin,
        input logic [17:0] xa, input logic [7:0] xd, input logic xwe, xen, xwait, xhold, xblank, xconf);
        vec_t v;
        v.rst = rst; v.dl = dl; v.wr = wr; v.idx = idx; v.iaddr = iaddr; v.idata = idata;
        v.eb = eb; v.ewr = ewr; v.eaddr = eaddr; v.edata = edata;
        v.vrd = vrd; v.vwr = vwr; v.vaddr = vaddr; v.vdin = vdin;
        v.xa = xa; v.xd = xd; v.xwe = xwe; v.xen = xen; v.xwait = xwait;
        v.xhold = xhold; v.xblank = xblank; v.xconf = xconf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL vec %0d %s: got 0x%0h expected 0x%0h", vec_no, name, act, exp);
        end
    endtask

    // Drive one cycle, compare the settled outputs, then advance one clock.
    task automatic apply(input vec_t v);
        exp_t e;
        reset = v.rst; ioctl_download = v.dl; ioctl_wr = v.wr; ioctl_index = v.idx;
        ioctl_addr = v.iaddr; ioctl_data = v.idata;
        eraser_busy = v.eb; eraser_wr = v.ewr; eraser_addr = v.eaddr; eraser_data = v.edata;
        vdc_rd = v.vrd; vdc_wr = v.vwr; vdc_addr = v.vaddr; vdc_din = v.vdin;
        e.addr = v.xa; e.din = v.xd; e.we = v.xwe; e.en = v.xen; e.wt = v.xwait;
        e.hold = v.xhold; e.blank = v.xblank; e.conf = v.xconf;
        exp_q.push_back(e);
        #1;
        e = exp_q.pop_front();
        check("ram_addr", 32'(ram_addr), 32'(e.addr));
        check("ram_din", 32'(ram_din), 32'(e.din));
        check("ram_we", 32'(ram_we), 32'(e.we));
        check("ram_en", 32'(ram_en), 32'(e.en));
        check("vdc_wait", 32'(vdc_wait), 32'(e.wt));
        check("cpu_hold", 32'(cpu_hold), 32'(e.hold));
        check("blank", 32'(blank), 32'(e.blank));
        check("erase_conflict", 32'(erase_conflict), 32'(e.conf));
        vec_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst dl wr idx iaddr idata | eb ewr eaddr edata | vrd vwr vaddr vdin | xa xd we en wait hold blank conf
        tbl.push_back(mk(1,0,0,0,0,0,        0,0,0,0,                1,0,25'h3,0,           0,0,0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,        0,0,0,0,                0,0,0,0,               0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,        0,0,0,0,                1,0,25'h1234,0,        18'h1234,0,0,1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,        0,0,0,0,                0,1,25'h1C0ABC,8'hA5,  18'h00ABC,8'hA5,1,1,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,        0,0,0,0,                0,0,0,0,               0,0,0,0,0,1,1,0));
        tbl.push_back(mk(0,1,1,0,25'h10,8'h5A, 0,0,0,0,              0,0,0,0,               18'h10,8'h5A,1,1,0,1,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,        0,1,25'h7,8'h9,         1,0,25'h3,0,           0,0,0,0,1,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,        0,0,0,0,                0,0,0,0,               0,0,0,0,0,1,1,1));
        tbl.push_back(mk(0,0,0,0,0,0,        0,0,0,0,                0,0,0,0,               0,0,0,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,        0,0,0,0,                0,0,0,0,               0,0,0,0,0,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,        0,0,0,0,                0,0,0,0,               0,0,0,0,0,0,0,0));
        // index-1 download of three bytes, then the four-byte pointer patch
        tbl.push_back(mk(0,1,0,1,0,0,        0,0,0,0,                0,0,0,0,               0,0,0,0,0,1,1,0));
        tbl.push_back(mk(0,1,1,1,25'h0,8'h11, 0,0,0,0,               0,0,0,0,               18'h08995,8'h11,1,1,0,1,1,0));
        tbl.push_back(mk(0,1,1,1,25'h1,8'h22, 0,0,0,0,               0,0,0,0,               18'h08996,8'h22,1,1,0,1,1,0));
        tbl.push_back(mk(0,1,1,1,25'h2,8'h33, 0,0,0,0,               0,0,0,0,               18'h08997,8'h33,1,1,0,1,1,0));
        tbl.push_back(mk(0,0,0,1,0,0,        0,0,0,0,                0,0,0,0,               0,0,0,0,0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,        0,0,0,0,                0,0,0,0,               18'h083E9,8'h98,1,1,0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,        0,0,0,0,                0,0,0,0,               18'h083EA,8'h89,1,1,0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,        0,0,0,0,                0,0,0,0,               18'h083EB,8'h98,1,1,0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,        0,0,0,0,                0,0,0,0,               18'h083EC,8'h89,1,1,0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,        0,0,0,0,                0,0,0,0,               0,0,0,0,0,0,0,0));
        // eraser pass-through with a VDC read held off
        tbl.push_back(mk(0,0,0,0,0,0,        1,0,0,0,                0,0,0,0,               0,0,0,0,0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,        1,1,25'h40123,8'hC3,    1,0,0,0,               18'h00123,8'hC3,1,1,1,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,        1,0,25'h200,0,          0,0,0,0,               18'h200,0,0,1,0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,        0,0,0,0,                1,0,25'h55,0,          0,0,0,1,1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,        0,0,0,0,                1,0,25'h55,0,          18'h55,0,0,1,0,0,0,0));

        // Unchecked reset cycle to put the design into a known state.
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Download pre-empts the patch at p=1; no further patch writes follow.
        apply(mk(0,1,0,1,0,0,         0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,1,0));
        apply(mk(0,1,1,1,25'h10,8'h77, 0,0,0,0, 0,0,0,0, 18'h089A5,8'h77,1,1,0,1,1,0));
        apply(mk(0,0,0,1,0,0,         0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,1,0));
        apply(mk(0,0,0,1,0,0,         0,0,0,0, 0,0,0,0, 18'h083E9,8'hA6,1,1,0,1,1,0));
        apply(mk(0,1,0,1,0,0,         0,0,0,0, 0,0,0,0, 18'h083EA,8'h89,1,1,0,1,1,0));
        apply(mk(0,1,0,1,0,0,         0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,1,0));
        apply(mk(0,0,0,1,0,0,         0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,1,0));
        apply(mk(0,0,0,0,0,0,         0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0));

        // Reset in the middle of an index-1 download: no write, no patch.
        apply(mk(0,1,0,1,0,0,         0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,1,0));
        apply(mk(0,1,1,1,25'h5,8'h44, 0,1,0,0, 0,0,0,0, 18'h0899A,8'h44,1,1,0,1,1,0));
        apply(mk(1,1,1,1,25'h6,8'h55, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,1,1));
        apply(mk(0,0,0,1,0,0,         0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0));
        apply(mk(0,0,0,0,0,0,         0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
